// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration table blocks: FSM state
// encoding, default sentinel, per-target entry widths and field slices.
package spi_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_RESTART   = 2'd2,
    ST_WAIT_DONE = 2'd3
  } cfg_state_t;

  // Entry widths: 16-bit-address parts (clock chip, ADC) and the 8-bit DAC.
  localparam int WIDE_ENTRY_W   = 25;
  localparam int NARROW_ENTRY_W = 16;

  // Default end-of-table marker for the wide table.
  localparam logic [WIDE_ENTRY_W-1:0] DEFAULT_SENTINEL = {WIDE_ENTRY_W{1'b1}};

  // Register address / data fields inside a wide entry.
  localparam int WIDE_ADDR_HI = 23;
  localparam int WIDE_ADDR_LO = 8;
  localparam int WIDE_DATA_HI = 7;
  localparam int WIDE_DATA_LO = 0;

  // Register address / data fields inside a narrow entry.
  localparam int NARROW_ADDR_HI = 15;
  localparam int NARROW_ADDR_LO = 8;
  localparam int NARROW_DATA_HI = 7;
  localparam int NARROW_DATA_LO = 0;

endpackage

// File: rtl/spi_lut_ram.sv
// Simple dual-port table memory: one write port, one registered read port.
// Kept free of reset and bypass logic so it maps onto block RAM. Any
// power-up contents come from the memory initialisation image at build time.
module spi_lut_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 25
) (
  input  logic              clk_50m,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write and registered read on the same edge (read returns old data).
  always_ff @(posedge clk_50m) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_lut_bank.sv
// Runtime-writable configuration table feeding the SPI sequencer. The host
// loads entries and commits; the block then holds the sequencer in reset for
// a fixed number of cycles and waits for it to report completion.
module spi_lut_bank
  import spi_cfg_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 25,
  parameter logic [DATA_W-1:0] SENTINEL    = {DATA_W{1'b1}},
  parameter int                INIT_COUNT  = 0,
  parameter int                RESTART_CYC = 16,
  parameter int                TIMEOUT_CYC = 2**24
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_commit,
  input  logic [ADDR_W:0]   host_len,
  input  logic              host_clear,
  input  logic [ADDR_W-1:0] lut_index,
  output logic [DATA_W-1:0] lut_data,
  output logic              cfg_run,
  input  logic              done_flag,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [ADDR_W:0]   active_count
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] INIT_CNT  = (ADDR_W+1)'(INIT_COUNT);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

  localparam int               RST_W    = $clog2(RESTART_CYC + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESTART_CYC - 1);
  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  cfg_state_t        state_reg;
  logic [RST_W-1:0]  restart_cnt_reg;
  logic [TMO_W-1:0]  timeout_cnt_reg;
  logic [ADDR_W-1:0] clr_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_prev_reg;
  logic              run_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              ready_reg;
  logic              in_range_reg;

  logic              wr_fire;
  logic              clearing;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W:0]   len_sat;
  logic              done_rise;

  // ready is only ever high in IDLE, so this also restricts writes to IDLE.
  assign wr_fire   = host_wr_valid && ready_reg;
  assign clearing  = (state_reg == ST_CLEAR);
  assign ram_we    = wr_fire || clearing;
  assign ram_waddr = clearing ? clr_ptr_reg : host_wr_addr;
  assign ram_wdata = clearing ? SENTINEL : host_wr_data;
  assign len_sat   = (host_len > DEPTH_CNT) ? DEPTH_CNT : host_len;
  assign done_rise = done_flag && !done_prev_reg;

  spi_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_50m (clk_50m),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr   (lut_index),
    .rdata   (ram_rdata)
  );

  // Range check registered alongside the RAM read so both line up one cycle
  // later; the index is zero-extended so a full-depth count admits all.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      in_range_reg <= 1'b0;
    end else begin
      in_range_reg <= ({1'b0, lut_index} < count_reg);
    end
  end

  assign lut_data = in_range_reg ? ram_rdata : SENTINEL;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_reg       <= ST_RESTART;
      restart_cnt_reg <= '0;
      timeout_cnt_reg <= '0;
      clr_ptr_reg     <= '0;
      count_reg       <= INIT_CNT;
      done_prev_reg   <= 1'b1;
      run_reg         <= 1'b0;
      busy_reg        <= 1'b1;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      ready_reg       <= 1'b0;
    end else begin
      done_prev_reg <= done_flag;
      case (state_reg)
        ST_IDLE: begin
          if (host_clear) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            count_reg   <= '0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
          end else if (host_commit) begin
            state_reg       <= ST_RESTART;
            restart_cnt_reg <= '0;
            count_reg       <= len_sat;
            err_reg         <= 1'b0;
            done_reg        <= 1'b0;
            run_reg         <= 1'b0;
            busy_reg        <= 1'b1;
            ready_reg       <= 1'b0;
          end
        end
        ST_CLEAR: begin
          count_reg   <= '0;
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == LAST_PTR) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        ST_RESTART: begin
          done_reg <= 1'b0;
          if (restart_cnt_reg == RST_LAST) begin
            state_reg       <= ST_WAIT_DONE;
            run_reg         <= 1'b1;
            timeout_cnt_reg <= '0;
            // A done_flag still high from the previous run must fall first.
            done_prev_reg   <= 1'b1;
          end else begin
            restart_cnt_reg <= restart_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (done_rise) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else if (timeout_cnt_reg == TMO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg       <= ST_RESTART;
          restart_cnt_reg <= '0;
          run_reg         <= 1'b0;
          busy_reg        <= 1'b1;
          ready_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign host_wr_ready = ready_reg;
  assign cfg_run       = run_reg;
  assign cfg_busy      = busy_reg;
  assign cfg_done      = done_reg;
  assign cfg_err       = err_reg;
  assign active_count  = count_reg;

endmodule

// File: tb/tb_spi_lut_bank.sv
// Directed bench for spi_lut_bank: restart timing, table load/readback,
// same-cycle write+commit, clear, timeout and mid-operation reset.
module tb_spi_lut_bank;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 25;
  localparam logic [31:0] SENT = 32'h1FF_FFFF;

  logic              clk_50m = 1'b0;
  logic              rst = 1'b1;
  logic              host_wr_valid = 1'b0;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr = '0;
  logic [DATA_W-1:0] host_wr_data = '0;
  logic              host_commit = 1'b0;
  logic [ADDR_W:0]   host_len = '0;
  logic              host_clear = 1'b0;
  logic [ADDR_W-1:0] lut_index = '0;
  logic [DATA_W-1:0] lut_data;
  logic              cfg_run;
  logic              done_flag = 1'b0;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;
  logic [ADDR_W:0]   active_count;

  int total = 0;
  int bad   = 0;

  always #10 clk_50m = ~clk_50m;

  spi_lut_bank #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .INIT_COUNT  (0),
    .RESTART_CYC (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_50m       (clk_50m),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_commit   (host_commit),
    .host_len      (host_len),
    .host_clear    (host_clear),
    .lut_index     (lut_index),
    .lut_data      (lut_data),
    .cfg_run       (cfg_run),
    .done_flag     (done_flag),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .active_count  (active_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  // Ticks until cfg_run is high; n = cycles spent with cfg_run low.
  task automatic wait_run_high(output int n);
    n = 0;
    while (cfg_run !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] idx, input logic [31:0] exp, input string tag);
    lut_index = idx;
    tick();
    check_val(tag, lut_data, exp);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    tick();
    host_wr_valid = 1'b0;
  endtask

  task automatic commit(input logic [ADDR_W:0] len);
    host_len    = len;
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
  endtask

  // Sequencer reports completion: low for a cycle, then rising.
  task automatic finish_seq(input string tag);
    done_flag = 1'b0;
    tick();
    done_flag = 1'b1;
    tick();
    check_val({tag, "_done"}, cfg_done, 1);
    check_val({tag, "_busy"}, cfg_busy, 0);
    check_val({tag, "_ready"}, host_wr_ready, 1);
    done_flag = 1'b0;
  endtask

  initial begin
    int n;
    bit run_low_seen;

    // Reset state and initial restart window.
    tick();
    check_val("rst_run", cfg_run, 0);
    check_val("rst_busy", cfg_busy, 1);
    check_val("rst_ready", host_wr_ready, 0);
    check_val("rst_done", cfg_done, 0);
    check_val("rst_err", cfg_err, 0);
    check_val("rst_lut", lut_data, SENT);
    check_val("rst_count", active_count, 0);
    rst = 1'b0;
    wait_run_high(n);
    check_val("rst_run_low_cyc", n, 16);
    rd(0, SENT, "empty_idx0");
    rd(1023, SENT, "empty_idx1023");
    finish_seq("first");

    // Load three entries and commit; a write during RESTART is refused.
    wr(0, 25'h000018);
    wr(1, 25'h0001A5);
    wr(2, 25'h023201);
    commit(3);
    host_wr_valid = 1'b1;
    host_wr_addr  = 1;
    host_wr_data  = 25'h155555;
    tick();
    host_wr_valid = 1'b0;
    wait_run_high(n);
    check_val("load_run_low_cyc", n + 1, 16);
    check_val("load_count", active_count, 3);
    rd(0, 32'h000018, "load_idx0");
    rd(1, 32'h0001A5, "load_idx1");
    rd(2, 32'h023201, "load_idx2");
    rd(3, SENT, "load_idx3");
    finish_seq("load");

    // Write and commit in the same cycle: write visible after restart.
    host_wr_valid = 1'b1;
    host_wr_addr  = 2;
    host_wr_data  = 25'h0ABCDE;
    commit(3);
    host_wr_valid = 1'b0;
    wait_run_high(n);
    rd(2, 32'h0ABCDE, "same_cyc_idx2");
    finish_seq("same_cyc");

    // Clear: ready low 1024 cycles; a commit mid-clear is ignored.
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    n = 0;
    run_low_seen = 1'b0;
    while (host_wr_ready !== 1'b1 && n < 2000) begin
      host_commit = (n == 10);
      tick();
      host_commit = 1'b0;
      if (cfg_run !== 1'b1) run_low_seen = 1'b1;
      n++;
    end
    check_val("clear_cyc", n, 1024);
    check_val("clear_run_stayed_high", run_low_seen, 0);
    check_val("clear_count", active_count, 0);
    rd(0, SENT, "clear_idx0_cnt0");
    // Oversized length saturates to full depth; RAM itself must hold SENTINEL.
    commit(11'h7FF);
    check_val("sat_count", active_count, 1024);
    wait_run_high(n);
    rd(0, SENT, "clear_ram_idx0");
    rd(1023, SENT, "clear_ram_idx1023");
    rd(2, SENT, "clear_ram_idx2");
    finish_seq("clear");

    // Stale high done_flag is ignored; timeout raises cfg_err.
    done_flag = 1'b1;
    commit(0);
    wait_run_high(n);
    n = 0;
    while (cfg_busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_val("tmo_wait_cyc", n, 100);
    check_val("tmo_err", cfg_err, 1);
    check_val("tmo_done", cfg_done, 0);
    rd(0, SENT, "len0_idx0");
    done_flag = 1'b0;
    commit(3);
    check_val("tmo_err_cleared", cfg_err, 0);

    // Reset during WAIT_DONE.
    wait_run_high(n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_wait_run", cfg_run, 0);
    check_val("rst_wait_ready", host_wr_ready, 0);
    check_val("rst_wait_done", cfg_done, 0);
    check_val("rst_wait_busy", cfg_busy, 1);
    check_val("rst_wait_count", active_count, 0);
    wait_run_high(n);
    check_val("rst_wait_run_low_cyc", n, 16);
    finish_seq("after_rst_wait");

    // Reset during CLEAR at pointer 500.
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_clr_run", cfg_run, 0);
    check_val("rst_clr_ready", host_wr_ready, 0);
    check_val("rst_clr_done", cfg_done, 0);
    check_val("rst_clr_busy", cfg_busy, 1);
    check_val("rst_clr_lut", lut_data, SENT);
    wait_run_high(n);
    check_val("rst_clr_run_low_cyc", n, 16);
    finish_seq("after_rst_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_lut_bank.md
Name: spi_lut_bank

Overview:
- Runtime-writable register table that feeds the SPI configuration sequencer's `lut_index`/`lut_data` read port. It replaces a fixed ROM.
- A host loads (address, data) entries, then commits. The block pulses the sequencer's run enable low to restart configuration and tracks completion via `done_flag`.
- One instance per converter table (clock chip, ADC, DAC).

Parameters:
- ADDR_W, 10, table index width; depth = 2**ADDR_W.
- DATA_W, 25, entry width (25 for 16-bit-address parts, 16 for the 8-bit DAC).
- SENTINEL, {DATA_W{1'b1}}, value returned for any index >= active count.
- INIT_COUNT, 0, active entry count after reset.
- RESTART_CYC, 16, cycles `cfg_run` is held low on a restart.
- TIMEOUT_CYC, 2**24, WAIT_DONE cycles before `cfg_err` is set.

Ports:
- clk_50m  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- host_wr_valid  in  1  write request.
- host_wr_ready  out  1  write accepted when valid&&ready.
- host_wr_addr  in  ADDR_W  entry index.
- host_wr_data  in  DATA_W  entry value.
- host_commit  in  1  one-cycle pulse; count <= host_len, then restart.
- host_len  in  ADDR_W+1  number of valid entries (0..2**ADDR_W).
- host_clear  in  1  one-cycle pulse; fill whole table with SENTINEL, count <= 0.
- lut_index  in  ADDR_W  sequencer read index.
- lut_data  out  DATA_W  registered read data.
- cfg_run  out  1  drives sequencer `locked`; low = hold in reset.
- done_flag  in  1  sequencer completion level.
- cfg_busy  out  1  high in CLEAR, RESTART, WAIT_DONE.
- cfg_done  out  1  set on `done_flag` rise in WAIT_DONE; cleared on entering RESTART.
- cfg_err  out  1  sticky timeout; cleared on commit or rst.
- active_count  out  ADDR_W+1  current count.

Behaviour:
- Reset (rst=1):
  - State -> RESTART, restart counter = 0, count = INIT_COUNT.
  - cfg_run=0, cfg_busy=1, cfg_done=0, cfg_err=0, host_wr_ready=0, lut_data=SENTINEL.
  - RAM contents are not reset; INIT_COUNT>0 relies on the RAM init image.
- Read path:
  - lut_data <= (lut_index < count) ? ram[lut_index] : SENTINEL.
  - One-cycle latency, valid in every state.
  - Comparison is zero-extended to ADDR_W+1 bits; count = 2**ADDR_W makes all indices valid.
- States:
  - IDLE: host_wr_ready=1, cfg_run=1, cfg_busy=0.
    - A write performs ram[addr] <= data on the same edge.
    - host_clear -> CLEAR.
    - Else host_commit -> RESTART, with count <= host_len and cfg_err <= 0.
  - CLEAR: pointer walks 0..2**ADDR_W-1, one SENTINEL write per cycle; count <= 0; host_wr_ready=0. After the last address -> IDLE (2**ADDR_W cycles in CLEAR).
  - RESTART: cfg_run=0, cfg_done=0, counter increments; when the counter reaches RESTART_CYC-1 -> WAIT_DONE.
  - WAIT_DONE: cfg_run=1, timeout counter runs.
    - done_flag rising edge (registered previous value, previous sampled low) -> cfg_done<=1, IDLE.
    - Counter reaching TIMEOUT_CYC-1 -> cfg_err<=1, IDLE (cfg_done stays 0).
    - On entry the done edge detector's previous value is forced to 1, so a stale high done_flag is ignored until it falls and rises again.
- Same-cycle priorities in IDLE:
  - A write and a commit in the same cycle both act: the write lands first and is visible to the restarted sequence.
  - host_clear beats host_commit; the commit is dropped.
  - Commit/clear pulses outside IDLE are ignored.
  - Writes are only accepted in IDLE.
- Wrap and range:
  - host_len > 2**ADDR_W is saturated to 2**ADDR_W.
  - host_len=0 is legal: the sequencer reads SENTINEL at index 0 and finishes immediately.
- Reset mid-operation (any state): returns to RESTART with the reset values above. A CLEAR in progress is abandoned (partial fill is acceptable, count = INIT_COUNT).

Decomposition:
- Package spi_cfg_pkg:
  - state encoding (IDLE, CLEAR, RESTART, WAIT_DONE);
  - default SENTINEL;
  - per-target entry widths (25/16);
  - address/data field slice constants ([23:8]/[7:0], [15:8]/[7:0]).
- One sub-module spi_lut_ram: single write port, registered read port, optional init file. Keeps the memory inferable as block RAM.
- FSM, counters and the read mux stay in spi_lut_bank.

Test Plan:
- Reset with INIT_COUNT=0 -> cfg_run low exactly 16 cycles, then high. Every lut_index returns 0x1FFFFFF one cycle later. Drive done_flag 0->1 -> cfg_done=1, cfg_busy=0.
- Write addr 0=0x000018, 1=0x0001A5, 2=0x023201, commit host_len=3 -> cfg_run low 16 cycles. Indices 0..2 return the written data, index 3 returns SENTINEL. active_count=3.
- Same-cycle write (addr 2=0x0ABCDE) plus commit -> index 2 reads 0x0ABCDE after restart.
- Clear pulse -> host_wr_ready low for 1024 cycles. Afterwards indices 0 and 1023 read SENTINEL and active_count=0. A commit during the clear is ignored (cfg_run stays 1).
- Commit with done_flag held high throughout -> no cfg_done. With TIMEOUT_CYC=100, cfg_err=1 after 100 WAIT_DONE cycles. The next commit clears cfg_err.
- Assert rst during WAIT_DONE and during CLEAR at pointer 500 -> next cycle state=RESTART, cfg_run=0, host_wr_ready=0, cfg_done=0.
